// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache with a single-line fill controller.
// Hits are served combinationally in IDLE. A miss latches the line address,
// requests the 4-word line from main memory and installs it on mem_rdy.
// LINES must be a power of two and at least 2.
module icache_ctrl #(
  parameter int LINES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] if_addr,
  input  logic        if_re,
  output logic [15:0] if_instr,
  output logic        if_hit,
  output logic        stall,
  input  logic        inv,
  output logic        mem_re,
  output logic [13:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [63:0] mem_line,
  output logic [15:0] miss_cnt
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 14 - IW;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t           state_q;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [63:0]      data_q [LINES];
  logic             mem_re_q;
  logic [13:0]      mem_addr_q;
  logic [15:0]      miss_cnt_q;
  logic [15:0]      miss_cnt_d;

  // Lookup fields of the fetch address.
  logic [1:0]    lk_off;
  logic [IW-1:0] lk_idx;
  logic [TW-1:0] lk_tag;
  logic          lk_match;
  logic          lk_miss;
  logic [63:0]   lk_line;
  logic [15:0]   lk_word;

  // Fill target, taken from the line address latched at the miss.
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic          fill_we;

  assign lk_off   = if_addr[1:0];
  assign lk_idx   = if_addr[IW+1:2];
  assign lk_tag   = if_addr[15:IW+2];
  assign lk_line  = data_q[lk_idx];
  assign lk_word  = lk_line[{lk_off, 4'b0000} +: 16];
  assign lk_match = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign fill_idx = mem_addr_q[IW-1:0];
  assign fill_tag = mem_addr_q[13:IW];
  assign fill_we  = (state_q == FILL) && mem_rdy;

  // Lookups are only served from IDLE; during FILL every request stalls.
  assign if_hit   = if_re && (state_q == IDLE) && lk_match;
  assign lk_miss  = if_re && (state_q == IDLE) && !lk_match;
  assign stall    = if_re && !if_hit;
  assign if_instr = if_hit ? lk_word : 16'h0000;

  assign mem_re   = mem_re_q;
  assign mem_addr = mem_addr_q;
  assign miss_cnt = miss_cnt_q;

  // Saturating increment for the performance counter.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (miss_cnt_q != 16'hFFFF) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  // Controller FSM: IDLE serves hits and launches fills, FILL waits for memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lk_miss) begin
            state_q    <= FILL;
            mem_re_q   <= 1'b1;
            mem_addr_q <= if_addr[15:2];
            miss_cnt_q <= miss_cnt_d;
          end
        end
        FILL: begin
          if (mem_rdy) begin
            state_q           <= IDLE;
            mem_re_q          <= 1'b0;
            valid_q[fill_idx] <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          mem_re_q <= 1'b0;
        end
      endcase
      // Invalidate overrides a coinciding fill's valid bit.
      if (inv) begin
        valid_q <= '0;
      end
    end
  end

  // Per-line tag and data storage, written only when a fill completes.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_line
    // Install the returned line into this entry when it is the fill target.
    always_ff @(posedge clk) begin
      if (fill_we && (fill_idx == IW'(gi))) begin
        tag_q[gi]  <= fill_tag;
        data_q[gi] <= mem_line;
      end
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: scoreboard bench for icache_ctrl. A reference model keeps
// which line address occupies each cache slot; expected memory requests and
// hit data are queued at issue time and checked by an independent monitor.
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_re = 1'b0;
  logic [15:0] if_instr;
  logic        if_hit;
  logic        stall;
  logic        inv_d = 1'b0;
  logic        inv_r = 1'b0;
  logic        inv;
  logic        mem_re;
  logic [13:0] mem_addr;
  logic        mem_rdy = 1'b0;
  logic [63:0] mem_line = '0;
  logic [15:0] miss_cnt;

  assign inv = inv_d | inv_r;

  icache_ctrl #(.LINES(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_addr  (if_addr),
    .if_re    (if_re),
    .if_instr (if_instr),
    .if_hit   (if_hit),
    .stall    (stall),
    .inv      (inv),
    .mem_re   (mem_re),
    .mem_addr (mem_addr),
    .mem_rdy  (mem_rdy),
    .mem_line (mem_line),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [13:0] exp_req [$];
  logic [15:0] exp_hit [$];

  // Reference model: resident line address per slot, plus miss count.
  logic [13:0] res_line [8];
  bit          res_ok   [8];
  logic [15:0] m_cnt = '0;

  // Memory responder controls/observations.
  int force_lat  = -1;
  int lat_acc    = 0;
  int pulse_no   = 0;
  int inv_target = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    tests++;
    fails++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Memory contents: word at address 4..7 is 1111..4444, other lines scrambled.
  function automatic logic [15:0] word_of(input logic [15:0] a);
    logic [3:0]  n;
    logic [15:0] k;
    n = 4'(a[1:0]) + 4'd1;
    k = 16'(a[15:2]) - 16'd1;
    return {n, n, n, n} ^ (k * 16'h9E37);
  endfunction

  function automatic logic [63:0] line_data(input logic [13:0] la);
    return {word_of({la, 2'd3}), word_of({la, 2'd2}), word_of({la, 2'd1}), word_of({la, 2'd0})};
  endfunction

  function automatic bit would_miss(input logic [15:0] a);
    int idx;
    idx = int'(a[15:2]) % 8;
    return !(res_ok[idx] && res_line[idx] == a[15:2]);
  endfunction

  // Looks up an access; on a miss queues the expected request and installs the line.
  function automatic bit model_access(input logic [15:0] a);
    int idx;
    idx = int'(a[15:2]) % 8;
    if (res_ok[idx] && res_line[idx] == a[15:2]) return 1'b0;
    exp_req.push_back(a[15:2]);
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    res_ok[idx]   = 1'b1;
    res_line[idx] = a[15:2];
    return 1'b1;
  endfunction

  function automatic void model_clear();
    foreach (res_ok[i]) res_ok[i] = 1'b0;
  endfunction

  // Memory: answer each new request after a random (or forced) latency.
  initial begin : responder
    logic [13:0] la;
    int          l;
    forever begin
      @(negedge clk);
      if (mem_re === 1'b1) begin
        la = mem_addr;
        l  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
        repeat (l) @(negedge clk);
        mem_line = line_data(la);
        mem_rdy  = 1'b1;
        if (pulse_no == inv_target) inv_r = 1'b1;
        pulse_no++;
        lat_acc += 2 + l;
        @(negedge clk);
        mem_rdy = 1'b0;
        inv_r   = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues a request or a hit.
  initial begin : monitor
    logic        re_prev;
    logic [13:0] addr_hold;
    re_prev   = 1'b0;
    addr_hold = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!if_re) begin
          check("idle_no_hit", if_hit, 1'b0);
          check("idle_no_stall", stall, 1'b0);
        end
        if (!if_hit) check("instr_zero_on_nohit", if_instr, 16'h0000);
        if (mem_re && !re_prev) begin
          if (exp_req.size() == 0) fail_now("mem_req", $sformatf("got request %0h, required none", mem_addr));
          else check("mem_addr", mem_addr, exp_req.pop_front());
          addr_hold = mem_addr;
        end else if (mem_re) begin
          check("mem_addr_stable", mem_addr, addr_hold);
        end
        if (if_hit) begin
          if (exp_hit.size() == 0) fail_now("hit", $sformatf("got hit %0h on %0h, required none", if_instr, if_addr));
          else begin
            logic [15:0] e;
            e = exp_hit.pop_front();
            $display("[TB] hit addr=%04h instr=%04h expected=%04h", if_addr, if_instr, e);
            check("hit_instr", if_instr, e);
          end
        end
      end
      re_prev = mem_re;
    end
  end

  task automatic wait_hit(input logic [15:0] a, output int stall_n);
    bit got;
    got     = 1'b0;
    stall_n = 0;
    for (int c = 0; c < 80 && !got; c++) begin
      @(negedge clk);
      if (if_hit) got = 1'b1;
      else if (stall) stall_n++;
    end
    if (!got) fail_now("hit_timeout", $sformatf("addr %04h got no hit in 80 cycles, hit required", a));
  endtask

  task automatic access(input logic [15:0] a, input int lat, input bit inv_fill);
    bit missed;
    int base;
    int stall_n;
    @(posedge clk); #1;
    missed = model_access(a);
    if (inv_fill) begin
      model_clear();
      void'(model_access(a));
      inv_target = pulse_no;
    end
    exp_hit.push_back(word_of(a));
    force_lat = lat;
    base      = lat_acc;
    if_addr   = a;
    if_re     = 1'b1;
    wait_hit(a, stall_n);
    check("stall_cycles", stall_n, missed ? (lat_acc - base) : 0);
    check("miss_cnt", miss_cnt, m_cnt);
    @(posedge clk); #1;
    if_re      = 1'b0;
    force_lat  = -1;
    inv_target = -1;
  endtask

  task automatic pulse_inv();
    @(posedge clk); #1;
    inv_d = 1'b1;
    model_clear();
    @(posedge clk); #1;
    inv_d = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if_addr = 16'($urandom);
    end
  endtask

  task automatic wait_fill(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (mem_re) seen = 1'b1;
    end
    if (!seen) fail_now(name, "mem_re not raised in 10 cycles, required high");
  endtask

  task automatic redirect(input logic [15:0] a1, input logic [15:0] a2);
    int stall_n;
    @(posedge clk); #1;
    void'(model_access(a1));
    void'(model_access(a2));
    exp_hit.push_back(word_of(a2));
    force_lat = 2;
    if_addr   = a1;
    if_re     = 1'b1;
    wait_fill("redirect_fill");
    @(posedge clk); #1;
    if_addr = a2;
    @(negedge clk);
    check("redirect_hold_addr", mem_addr, {2'b00, a1[15:2]});
    wait_hit(a2, stall_n);
    check("redirect_miss_cnt", miss_cnt, m_cnt);
    @(posedge clk); #1;
    if_re     = 1'b0;
    force_lat = -1;
  endtask

  task automatic reset_mid_fill(input logic [15:0] a);
    @(posedge clk); #1;
    void'(model_access(a));
    force_lat = 6;
    if_addr   = a;
    if_re     = 1'b1;
    wait_fill("rst_fill");
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_re", mem_re, 1'b0);
    check("rst_mem_addr", mem_addr, 14'h0);
    check("rst_miss_cnt", miss_cnt, 16'h0);
    check("rst_if_hit", if_hit, 1'b0);
    model_clear();
    m_cnt = '0;
    if_re = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    force_lat = -1;
    check("rst_late_rdy_cnt", miss_cnt, 16'h0);
    check("rst_late_rdy_mem_re", mem_re, 1'b0);
  endtask

  initial begin : driver
    int          r;
    logic [15:0] a;
    // Reset state while a fetch is already being requested.
    if_re   = 1'b1;
    if_addr = 16'h0004;
    #12;
    check("reset_if_hit", if_hit, 1'b0);
    check("reset_if_instr", if_instr, 16'h0000);
    check("reset_stall", stall, 1'b1);
    check("reset_mem_re", mem_re, 1'b0);
    check("reset_mem_addr", mem_addr, 14'h0);
    check("reset_miss_cnt", miss_cnt, 16'h0);
    if_re = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Cold miss with 3-cycle memory latency, then a hit in the same line.
    access(16'h0004, 3, 1'b0);
    access(16'h0007, -1, 1'b0);
    check("cold_miss_cnt", miss_cnt, 16'd1);

    // Conflict on index 1.
    access(16'h0024, -1, 1'b0);
    access(16'h0004, -1, 1'b0);
    check("conflict_miss_cnt", miss_cnt, 16'd3);

    // Redirect during fill; the original line still lands.
    redirect(16'h0010, 16'h0100);
    access(16'h0010, -1, 1'b0);

    // Invalidate two filled lines.
    access(16'h0008, -1, 1'b0);
    access(16'h000C, -1, 1'b0);
    pulse_inv();
    access(16'h0008, -1, 1'b0);
    access(16'h000C, -1, 1'b0);

    // Invalidate coincident with fill completion.
    access(16'h0030, 1, 1'b1);

    // Reset in the middle of a fill, then the same address misses again.
    reset_mid_fill(16'h0200);
    access(16'h0200, -1, 1'b0);

    // Randomized traffic over a few tags so hits and conflicts both occur.
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) pulse_inv();
      else if (r == 1) idle(int'($urandom_range(1, 4)));
      else begin
        a = 16'(($urandom_range(0, 2) << 5) | $urandom_range(0, 31));
        access(a, -1, (r == 2) && would_miss(a));
      end
    end

    // Saturation: preload the counter just below the limit.
    @(negedge clk);
    force dut.miss_cnt_q = 16'hFFFD;
    @(posedge clk); #1;
    release dut.miss_cnt_q;
    m_cnt = 16'hFFFD;
    check("preload_cnt", miss_cnt, 16'hFFFD);
    for (int k = 0; k < 4; k++) begin
      access((k % 2 == 0) ? 16'h0000 : 16'h0020, -1, 1'b0);
    end
    check("sat_cnt", miss_cnt, 16'hFFFF);

    repeat (4) @(negedge clk);
    check("req_queue_drained", 64'(exp_req.size()), 64'd0);
    check("hit_queue_drained", 64'(exp_hit.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction cache plus fill controller, placed between the instruction-fetch stage and a multi-cycle main memory. Hits return the 16-bit instruction combinationally in the same cycle. A miss raises `stall` to hold the pipeline while the controller fetches a 4-word line over a request/ready handshake, then installs it. It also supports whole-cache invalidation and keeps a saturating miss counter for performance measurement.

## Interface
- `LINES`, 8: number of cache lines; a power of two. The index width is log2(LINES).
- `clk` in 1: clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `if_addr` in 16: word address of the instruction, driven by fetch (the pc).
- `if_re` in 1: fetch read request.
- `if_instr` out 16: instruction word; 16'h0000 whenever `if_hit`=0.
- `if_hit` out 1: `if_instr` is valid this cycle.
- `stall` out 1: `if_re & ~if_hit`; fetch holds the pc while this is high.
- `inv` in 1: invalidate all lines (synchronous).
- `mem_re` out 1: line read request to main memory.
- `mem_addr` out 14: line address, equal to `if_addr[15:2]` latched at the miss.
- `mem_rdy` in 1: `mem_line` is valid; a single-cycle pulse.
- `mem_line` in 64: fill data; word k occupies bits [16k+15:16k].
- `miss_cnt` out 16: count of misses, saturating at 16'hFFFF.

## Operation
- Address fields:
  - offset = `if_addr[1:0]`
  - index = `if_addr[1+log2(LINES):2]`
  - tag = the remaining upper bits (11 bits when LINES=8)
- Storage per line: a valid bit, the tag, and 64 bits of data. Storage is flop-based with no reset on data or tag.
- Hit: `if_re` & valid[index] & (tag == stored tag) while state=IDLE. A hit drives `if_hit`=1 and the selected word on `if_instr`.
- FSM states: IDLE and FILL.
- IDLE:
  - On a read miss (`if_re`=1, no hit), latch `if_addr[15:2]` into `mem_addr` and go to FILL.
  - Increment `miss_cnt` once, unless it is already at 16'hFFFF.
- FILL:
  - `mem_re`=1 for the whole state.
  - `if_hit`=0 regardless of tag state, so no lookups are served during a fill.
  - On `mem_rdy`=1, write `mem_line` and the latched tag into the latched index, set valid, and return to IDLE.
  - `mem_rdy` seen while in IDLE is ignored.
- Redirect during FILL (`if_addr` changes, for example on a branch): the fill still completes for the latched address. The new address is looked up once the controller is back in IDLE.
- `inv`:
  - On the next edge, clears every valid bit. Does not change state.
  - If `inv` and a completing fill (`mem_rdy`) coincide, the data and tag are written but valid stays 0; `inv` wins.
  - `inv` in IDLE forces a miss on the following cycle.
- `if_re`=0: no miss is recorded, `stall`=0, `if_hit`=0.
- A fill overwrites the old line at that index unconditionally. The cache is read-only, so there are no write-backs.

## Timing
- Reset values:
  - state=IDLE
  - all valid bits 0
  - `mem_re`=0, `mem_addr`=0
  - `miss_cnt`=0
  - `if_hit`=0, `if_instr`=16'h0000
  - `stall` = `if_re` (every access misses)
- Reset asserted mid-FILL aborts the fill immediately. A `mem_rdy` arriving after reset is ignored.
- Hit latency is 0 cycles (combinational).
- Miss timeline, with edges counted from the miss cycle T:
  - T: miss detected, `stall`=1.
  - T+1: FILL, `mem_re`=1.
  - First `mem_rdy` at cycle T+1+L: the line is installed on that edge.
  - T+2+L: hit.
- Minimum miss penalty is 2 cycles (L=0, memory ready on the first request cycle).
- `mem_re` is registered and glitch-free. `mem_addr` is stable for the whole FILL state.
- `stall` and `if_hit` are combinational from state, `if_addr`, `if_re`, valid, and tag.

## Test plan
- Cold miss:
  - Stimulus: after reset, `if_re`=1, `if_addr`=16'h0004; memory returns `mem_line`=64'h4444_3333_2222_1111 after 3 cycles.
  - Required: `mem_addr`=14'h0001; `stall`=1 for 5 cycles; then `if_hit`=1 with `if_instr`=16'h1111.
  - Follow-on: `if_addr`=16'h0007 hits immediately with 16'h4444; `miss_cnt`=1.
- Conflict:
  - Stimulus: fill 16'h0004, then access 16'h0024, which has the same index and a different tag.
  - Required: a miss, and the refill replaces the line; a repeat access to 16'h0004 misses again; `miss_cnt`=3.
- Redirect during fill:
  - Stimulus: miss on 16'h0010, then switch `if_addr` to 16'h0100 during FILL.
  - Required: `mem_addr` stays 14'h0004; after the fill, 16'h0100 misses and issues `mem_addr`=14'h0040.
- Invalidate:
  - Stimulus: fill 2 lines, pulse `inv`.
  - Required: both addresses miss afterwards.
  - Stimulus: `inv` coincident with `mem_rdy`.
  - Required: that address misses on the next cycle.
- Reset mid-fill:
  - Stimulus: assert `rst_n`=0 during FILL.
  - Required: `mem_re` drops at once; a later `mem_rdy` pulse installs nothing; `miss_cnt`=0.
- Saturation:
  - Stimulus: force 65,536+ misses (or preload near the limit).
  - Required: `miss_cnt` holds at 16'hFFFF.
